mem_arb_2r2w_1r1w: RTL and testbench
====================================

# mem_arb_2r2w_1r1w

Round-robin arbiter that shares one 1R1W-port memory (the `mem_beh_1r1w1p` model or its hard-macro equivalent) between two read clients and two write clients. It grants at most one read and one write per cycle and registers the winning commands onto the memory ports. It tags each issued read so the returned data is steered back to its requester after the memory latency. Out-of-range requests are screened here, so the memory never sees an illegal address.

## Interface
- AW, 10, word address width
- DW, 32, data width
- WORDS, 1024, words per bank
- BANKS, 1, number of banks
- BAW, 1, bank index width; minimum 1
- LATENCY, 2, memory read latency in cycles; legal range 0..29

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rd_req_0 / rd_req_1  in  1  read request, held until granted
- rd_addr_0 / rd_addr_1  in  AW  read word address
- rd_bank_0 / rd_bank_1  in  BAW  read bank
- rd_gnt_0 / rd_gnt_1  out  1  read grant, combinational in the request cycle
- rd_vld_0 / rd_vld_1  out  1  read data valid, one-cycle pulse
- rd_err  out  1  qualifies rd_vld_*: the read was out of range
- rd_dout  out  DW  read data, shared by both clients
- wr_req_0 / wr_req_1  in  1  write request, held until granted
- wr_addr_0 / wr_addr_1  in  AW  write word address
- wr_bank_0 / wr_bank_1  in  BAW  write bank
- wr_bw_0 / wr_bw_1  in  DW  bit-write enables
- wr_din_0 / wr_din_1  in  DW  write data
- wr_gnt_0 / wr_gnt_1  out  1  write grant, combinational
- wr_err  out  1  pulse: a granted write was dropped as out of range
- err_stky  out  1  sticky OR of rd_err-with-valid and wr_err; cleared only by rst
- mem_read, mem_raddr[AW], mem_rbank[BAW]  out  memory read port
- mem_dout  in  DW  memory read data
- mem_write, mem_waddr[AW], mem_wbank[BAW], mem_bw[DW], mem_din[DW]  out  memory write port

## Operation
- Read and write arbitration are independent. Each has a 1-bit round-robin pointer `rr`, naming the preferred client.
- Only requester: it wins. Both requesting: client `rr` wins. After any grant, `rr` becomes the loser's index. `rr` is unchanged in cycles with no grant.
- Grant conditions: `gnt_i = req_i & ~rst & won_i`. A client samples its grant and may drop or change its request at the next edge.
- Range check on the granted command: `addr >= WORDS || bank >= BANKS`.
  - In-range read: registered onto mem_read, mem_raddr and mem_rbank.
  - In-range write: registered onto mem_write and the other write-port outputs.
  - Out-of-range read: consumed with mem_read=0. It still returns rd_vld with rd_err=1 and rd_dout=0.
  - Out-of-range write: consumed with mem_write=0. wr_err pulses.
- Return path: a tag shift register of depth LATENCY+1 carries {valid, id, err}. At the output stage, rd_vld_id=1 and rd_dout = err ? 0 : mem_dout.
- Same-cycle read and write to the same address are issued together with no forwarding. The read returns the pre-write contents, matching the memory model.
- Arithmetic: address compares are unsigned, zero-extended to 32 bits. No bank*WORDS arithmetic is done here.

## Timing
- Request at cycle T, grant in T.
- mem_read/mem_write asserted in T+1.
- wr_err at T+1.
- rd_vld_*, rd_err and rd_dout at T+1+LATENCY. With LATENCY=0 this is T+1, taken from combinational mem_dout.
- Throughput: one read and one write per cycle, sustained. No bubbles under back-to-back requests.
- Reset values (forced by rst at the clock edge), all 0:
  - mem_read, mem_write, all memory address/data outputs
  - rd_vld_*, rd_err, rd_dout, wr_err, err_stky
  - both `rr` (client 0 preferred)
  - all tag stages
- While rst is high, rd_gnt_* and wr_gnt_* are 0.
- Reset mid-operation: in-flight reads are discarded with no rd_vld after rst. Memory data arriving later is ignored.
- Simultaneous rd_vld and a new grant to the same client are legal.

## Test plan
- Single read, LATENCY=2: rd_req_0 with addr 5 at T, after a write of 0xA5A5A5A5 to addr 5 completes.
  - rd_gnt_0 in T.
  - mem_read=1 with mem_raddr=5 at T+1.
  - rd_vld_0=1 with rd_dout=0xA5A5A5A5 at T+3.
- Contention: both read clients request continuously for 6 cycles from reset.
  - Grants alternate 0,1,0,1,0,1.
  - rd_vld pulses return in the same order, each LATENCY+1 cycles after its grant.
- Bit-write: write 0xFFFF0000 to addr 3 with bw=0x0000FFFF over a prior value of 0x12345678.
  - A later read of addr 3 returns 0x12340000.
- Out-of-range: wr_req_1 to addr WORDS, and rd_req_0 to bank BANKS with BANKS=1, BAW=1.
  - Both are granted; mem_write=0 and mem_read=0.
  - wr_err at T+1; rd_vld_0 with rd_err=1 and rd_dout=0 at T+1+LATENCY.
  - err_stky=1 and stays high until rst.
- Read and write to addr 7 in the same cycle: the read returns the old value, and a following read returns the new value.
- Reset mid-flight: rst for one cycle at T+2 after a read granted at T, with LATENCY=3.
  - No rd_vld is observed thereafter.
  - Arbitration restarts with client 0 preferred.

Source files
------------

// File: rtl/mem_arb_2r2w_1r1w.sv
// rtl/mem_arb_2r2w_1r1w.sv - two-read/two-write round-robin arbiter onto one 1R1W memory
// Range-screens granted commands and tags reads so data returns to its requester.
module mem_arb_2r2w_1r1w #(
  parameter int AW      = 10,
  parameter int DW      = 32,
  parameter int WORDS   = 1024,
  parameter int BANKS   = 1,
  parameter int BAW     = 1,
  parameter int LATENCY = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rd_req_0,
  input  logic           rd_req_1,
  input  logic [AW-1:0]  rd_addr_0,
  input  logic [AW-1:0]  rd_addr_1,
  input  logic [BAW-1:0] rd_bank_0,
  input  logic [BAW-1:0] rd_bank_1,
  output logic           rd_gnt_0,
  output logic           rd_gnt_1,
  output logic           rd_vld_0,
  output logic           rd_vld_1,
  output logic           rd_err,
  output logic [DW-1:0]  rd_dout,
  input  logic           wr_req_0,
  input  logic           wr_req_1,
  input  logic [AW-1:0]  wr_addr_0,
  input  logic [AW-1:0]  wr_addr_1,
  input  logic [BAW-1:0] wr_bank_0,
  input  logic [BAW-1:0] wr_bank_1,
  input  logic [DW-1:0]  wr_bw_0,
  input  logic [DW-1:0]  wr_bw_1,
  input  logic [DW-1:0]  wr_din_0,
  input  logic [DW-1:0]  wr_din_1,
  output logic           wr_gnt_0,
  output logic           wr_gnt_1,
  output logic           wr_err,
  output logic           err_stky,
  output logic           mem_read,
  output logic [AW-1:0]  mem_raddr,
  output logic [BAW-1:0] mem_rbank,
  input  logic [DW-1:0]  mem_dout,
  output logic           mem_write,
  output logic [AW-1:0]  mem_waddr,
  output logic [BAW-1:0] mem_wbank,
  output logic [DW-1:0]  mem_bw,
  output logic [DW-1:0]  mem_din
);

  localparam logic [31:0] LP_WORDS = 32'(WORDS);
  localparam logic [31:0] LP_BANKS = 32'(BANKS);

  typedef struct packed {
    logic vld;
    logic id;
    logic err;
  } tag_t;

  logic           r_rd_rr;
  logic           r_wr_rr;
  tag_t           r_tag [LATENCY+1];
  logic           r_err_stky;
  logic           w_rd_any;
  logic           w_wr_any;
  logic [AW-1:0]  w_rd_addr;
  logic [BAW-1:0] w_rd_bank;
  logic [AW-1:0]  w_wr_addr;
  logic [BAW-1:0] w_wr_bank;
  logic           w_rd_oor;
  logic           w_wr_oor;
  tag_t           w_out;

  // A client wins when it is the only requester or the pointer names it.
  assign rd_gnt_0 = ~rst & rd_req_0 & (~rd_req_1 | ~r_rd_rr);
  assign rd_gnt_1 = ~rst & rd_req_1 & (~rd_req_0 |  r_rd_rr);
  assign wr_gnt_0 = ~rst & wr_req_0 & (~wr_req_1 | ~r_wr_rr);
  assign wr_gnt_1 = ~rst & wr_req_1 & (~wr_req_0 |  r_wr_rr);

  assign w_rd_any  = rd_gnt_0 | rd_gnt_1;
  assign w_wr_any  = wr_gnt_0 | wr_gnt_1;
  assign w_rd_addr = rd_gnt_1 ? rd_addr_1 : rd_addr_0;
  assign w_rd_bank = rd_gnt_1 ? rd_bank_1 : rd_bank_0;
  assign w_wr_addr = wr_gnt_1 ? wr_addr_1 : wr_addr_0;
  assign w_wr_bank = wr_gnt_1 ? wr_bank_1 : wr_bank_0;
  assign w_rd_oor  = (32'(w_rd_addr) >= LP_WORDS) || (32'(w_rd_bank) >= LP_BANKS);
  assign w_wr_oor  = (32'(w_wr_addr) >= LP_WORDS) || (32'(w_wr_bank) >= LP_BANKS);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_rr    <= 1'b0;
      r_wr_rr    <= 1'b0;
      mem_read   <= 1'b0;
      mem_raddr  <= '0;
      mem_rbank  <= '0;
      mem_write  <= 1'b0;
      mem_waddr  <= '0;
      mem_wbank  <= '0;
      mem_bw     <= '0;
      mem_din    <= '0;
      wr_err     <= 1'b0;
      r_err_stky <= 1'b0;
    end else begin
      // Pointer moves to the loser, i.e. away from whoever was just served.
      if (w_rd_any) r_rd_rr <= rd_gnt_0;
      if (w_wr_any) r_wr_rr <= wr_gnt_0;
      mem_read  <= w_rd_any & ~w_rd_oor;
      mem_write <= w_wr_any & ~w_wr_oor;
      wr_err    <= w_wr_any & w_wr_oor;
      if (w_rd_any && !w_rd_oor) begin
        mem_raddr <= w_rd_addr;
        mem_rbank <= w_rd_bank;
      end
      if (w_wr_any && !w_wr_oor) begin
        mem_waddr <= w_wr_addr;
        mem_wbank <= w_wr_bank;
        mem_bw    <= wr_gnt_1 ? wr_bw_1  : wr_bw_0;
        mem_din   <= wr_gnt_1 ? wr_din_1 : wr_din_0;
      end
      r_err_stky <= r_err_stky | rd_err | wr_err;
    end
  end

  // Stage 0 lines up with mem_read; stage LATENCY lines up with mem_dout.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= LATENCY; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= '{vld: w_rd_any, id: rd_gnt_1, err: w_rd_oor};
      for (int i = 1; i <= LATENCY; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign w_out    = r_tag[LATENCY];
  assign rd_vld_0 = w_out.vld & ~w_out.id;
  assign rd_vld_1 = w_out.vld &  w_out.id;
  assign rd_err   = w_out.vld &  w_out.err;
  assign rd_dout  = (w_out.vld && !w_out.err) ? mem_dout : '0;
  assign err_stky = r_err_stky;

endmodule

// File: tb/tb_mem_arb_2r2w_1r1w.sv
// tb/tb_mem_arb_2r2w_1r1w.sv - directed bench for mem_arb_2r2w_1r1w with a 2-cycle memory model
// WORDS is shrunk to 512 so an out-of-range address is expressible in 10 bits.
module tb_mem_arb_2r2w_1r1w;
  localparam int AW = 10, DW = 32, WORDS = 512, BANKS = 1, BAW = 1, LAT = 2;

  logic clk = 1'b0, rst = 1'b1;
  logic rd_req_0 = 0, rd_req_1 = 0;
  logic [AW-1:0] rd_addr_0 = '0, rd_addr_1 = '0;
  logic [BAW-1:0] rd_bank_0 = '0, rd_bank_1 = '0;
  logic rd_gnt_0, rd_gnt_1, rd_vld_0, rd_vld_1, rd_err;
  logic [DW-1:0] rd_dout;
  logic wr_req_0 = 0, wr_req_1 = 0;
  logic [AW-1:0] wr_addr_0 = '0, wr_addr_1 = '0;
  logic [BAW-1:0] wr_bank_0 = '0, wr_bank_1 = '0;
  logic [DW-1:0] wr_bw_0 = '0, wr_bw_1 = '0, wr_din_0 = '0, wr_din_1 = '0;
  logic wr_gnt_0, wr_gnt_1, wr_err, err_stky;
  logic mem_read, mem_write;
  logic [AW-1:0] mem_raddr, mem_waddr;
  logic [BAW-1:0] mem_rbank, mem_wbank;
  logic [DW-1:0] mem_dout, mem_bw, mem_din;

  int n_checks = 0, n_fail = 0;

  mem_arb_2r2w_1r1w #(.AW(AW), .DW(DW), .WORDS(WORDS), .BANKS(BANKS), .BAW(BAW), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .rd_req_0(rd_req_0), .rd_req_1(rd_req_1), .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1),
    .rd_bank_0(rd_bank_0), .rd_bank_1(rd_bank_1), .rd_gnt_0(rd_gnt_0), .rd_gnt_1(rd_gnt_1),
    .rd_vld_0(rd_vld_0), .rd_vld_1(rd_vld_1), .rd_err(rd_err), .rd_dout(rd_dout),
    .wr_req_0(wr_req_0), .wr_req_1(wr_req_1), .wr_addr_0(wr_addr_0), .wr_addr_1(wr_addr_1),
    .wr_bank_0(wr_bank_0), .wr_bank_1(wr_bank_1), .wr_bw_0(wr_bw_0), .wr_bw_1(wr_bw_1),
    .wr_din_0(wr_din_0), .wr_din_1(wr_din_1), .wr_gnt_0(wr_gnt_0), .wr_gnt_1(wr_gnt_1),
    .wr_err(wr_err), .err_stky(err_stky),
    .mem_read(mem_read), .mem_raddr(mem_raddr), .mem_rbank(mem_rbank), .mem_dout(mem_dout),
    .mem_write(mem_write), .mem_waddr(mem_waddr), .mem_wbank(mem_wbank), .mem_bw(mem_bw),
    .mem_din(mem_din)
  );

  always #5 clk = ~clk;

  // Behavioural 1R1W memory: read sampled with the write edge sees old data.
  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] p1 = '0, p2 = '0;
  always @(posedge clk) begin
    if (mem_write) mem[mem_waddr] <= (mem[mem_waddr] & ~mem_bw) | (mem_din & mem_bw);
    p1 <= mem_read ? mem[mem_raddr] : '0;
    p2 <= p1;
  end
  assign mem_dout = p2;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(negedge clk);
  endtask

  task automatic set_rd(input bit c, input bit req, input logic [AW-1:0] a, input logic [BAW-1:0] b);
    if (c) begin rd_req_1 = req; rd_addr_1 = a; rd_bank_1 = b; end
    else   begin rd_req_0 = req; rd_addr_0 = a; rd_bank_0 = b; end
  endtask

  task automatic set_wr(input bit c, input bit req, input logic [AW-1:0] a,
                        input logic [DW-1:0] bw, input logic [DW-1:0] d);
    if (c) begin wr_req_1 = req; wr_addr_1 = a; wr_bw_1 = bw; wr_din_1 = d; wr_bank_1 = '0; end
    else   begin wr_req_0 = req; wr_addr_0 = a; wr_bw_0 = bw; wr_din_0 = d; wr_bank_0 = '0; end
  endtask

  task automatic do_write(input bit c, input logic [AW-1:0] a, input logic [DW-1:0] bw, input logic [DW-1:0] d);
    next_cyc(); set_wr(c, 1, a, bw, d); #1;
    check_eq("wr_gnt", 32'(c ? wr_gnt_1 : wr_gnt_0), 32'd1);
    next_cyc(); set_wr(c, 0, a, bw, d); #1;
    check_eq("mem_write", 32'(mem_write), 32'd1);
    check_eq("mem_waddr", 32'(mem_waddr), 32'(a));
  endtask

  task automatic do_read(input bit c, input logic [AW-1:0] a, input logic [DW-1:0] exp_d);
    next_cyc(); set_rd(c, 1, a, '0); #1;
    check_eq("rd_gnt", 32'(c ? rd_gnt_1 : rd_gnt_0), 32'd1);
    next_cyc(); set_rd(c, 0, a, '0); #1;
    check_eq("mem_read", 32'(mem_read), 32'd1);
    check_eq("mem_raddr", 32'(mem_raddr), 32'(a));
    next_cyc(); #1;
    check_eq("rd_vld_early", 32'(rd_vld_0 | rd_vld_1), 32'd0);
    next_cyc(); #1;
    check_eq("rd_vld", 32'(c ? rd_vld_1 : rd_vld_0), 32'd1);
    check_eq("rd_err", 32'(rd_err), 32'd0);
    check_eq("rd_dout", rd_dout, exp_d);
  endtask

  task automatic pulse_rst();
    next_cyc(); rst = 1;
    next_cyc(); rst = 0;
  endtask

  initial begin
    // Reset state, and grants held off while rst is high.
    repeat (3) next_cyc();
    rd_req_0 = 1; wr_req_0 = 1; #1;
    check_eq("rst_rd_gnt", 32'(rd_gnt_0), 32'd0);
    check_eq("rst_wr_gnt", 32'(wr_gnt_0), 32'd0);
    check_eq("rst_mem_read", 32'(mem_read), 32'd0);
    check_eq("rst_mem_write", 32'(mem_write), 32'd0);
    check_eq("rst_rd_vld", 32'(rd_vld_0 | rd_vld_1), 32'd0);
    check_eq("rst_stky", 32'(err_stky), 32'd0);
    check_eq("rst_dout", rd_dout, 32'd0);
    rd_req_0 = 0; wr_req_0 = 0;
    next_cyc(); rst = 0;

    // Single write then read of addr 5.
    do_write(0, 10'd5, 32'hFFFF_FFFF, 32'hA5A5_A5A5);
    do_read(0, 10'd5, 32'hA5A5_A5A5);

    // Read contention from reset: grants alternate, returns follow LAT+1 later.
    pulse_rst();
    for (int c = 0; c < 10; c++) begin
      next_cyc();
      set_rd(0, c < 6, 10'd5, '0);
      set_rd(1, c < 6, 10'd5, '0);
      #1;
      check_eq($sformatf("cont_gnt0_%0d", c), 32'(rd_gnt_0), 32'(c < 6 && c % 2 == 0));
      check_eq($sformatf("cont_gnt1_%0d", c), 32'(rd_gnt_1), 32'(c < 6 && c % 2 == 1));
      check_eq($sformatf("cont_vld0_%0d", c), 32'(rd_vld_0), 32'(c >= 3 && c < 9 && (c - 3) % 2 == 0));
      check_eq($sformatf("cont_vld1_%0d", c), 32'(rd_vld_1), 32'(c >= 3 && c < 9 && (c - 3) % 2 == 1));
    end

    // Bit-write merge.
    do_write(1, 10'd3, 32'hFFFF_FFFF, 32'h1234_5678);
    do_write(0, 10'd3, 32'h0000_FFFF, 32'hFFFF_0000);
    do_read(1, 10'd3, 32'h1234_0000);

    // Out-of-range write (addr WORDS) and read (bank BANKS) together.
    next_cyc();
    set_rd(0, 1, 10'd0, 1'b1);
    set_wr(1, 1, 10'd512, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
    #1;
    check_eq("oor_rd_gnt", 32'(rd_gnt_0), 32'd1);
    check_eq("oor_wr_gnt", 32'(wr_gnt_1), 32'd1);
    next_cyc(); set_rd(0, 0, 10'd0, 1'b0); set_wr(1, 0, 10'd0, '0, '0); #1;
    check_eq("oor_mem_read", 32'(mem_read), 32'd0);
    check_eq("oor_mem_write", 32'(mem_write), 32'd0);
    check_eq("oor_wr_err", 32'(wr_err), 32'd1);
    next_cyc(); #1;
    check_eq("oor_wr_err_pulse", 32'(wr_err), 32'd0);
    check_eq("oor_stky", 32'(err_stky), 32'd1);
    next_cyc(); #1;
    check_eq("oor_rd_vld", 32'(rd_vld_0), 32'd1);
    check_eq("oor_rd_err", 32'(rd_err), 32'd1);
    check_eq("oor_rd_dout", rd_dout, 32'd0);
    repeat (3) next_cyc();
    #1 check_eq("oor_stky_hold", 32'(err_stky), 32'd1);

    // Same-cycle read and write of addr 7: old data first, new data after.
    do_write(0, 10'd7, 32'hFFFF_FFFF, 32'h1111_1111);
    next_cyc();
    set_rd(0, 1, 10'd7, '0);
    set_wr(0, 1, 10'd7, 32'hFFFF_FFFF, 32'h2222_2222);
    #1;
    check_eq("rw_rd_gnt", 32'(rd_gnt_0), 32'd1);
    check_eq("rw_wr_gnt", 32'(wr_gnt_0), 32'd1);
    next_cyc(); set_rd(0, 0, 10'd7, '0); set_wr(0, 0, 10'd7, '0, '0);
    repeat (2) next_cyc();
    #1;
    check_eq("rw_old_vld", 32'(rd_vld_0), 32'd1);
    check_eq("rw_old", rd_dout, 32'h1111_1111);
    do_read(0, 10'd7, 32'h2222_2222);

    // Reset two cycles after a grant: the read never returns, pointer restarts at 0.
    next_cyc(); set_rd(0, 1, 10'd5, '0); #1;
    check_eq("mid_gnt", 32'(rd_gnt_0), 32'd1);
    next_cyc(); set_rd(0, 0, 10'd5, '0);
    next_cyc(); rst = 1;
    next_cyc(); rst = 0;
    for (int c = 0; c < 5; c++) begin
      #1 check_eq($sformatf("mid_no_vld_%0d", c), 32'(rd_vld_0 | rd_vld_1), 32'd0);
      next_cyc();
    end
    check_eq("mid_stky_clr", 32'(err_stky), 32'd0);
    set_rd(0, 1, 10'd5, '0); set_rd(1, 1, 10'd5, '0); #1;
    check_eq("mid_rr_gnt0", 32'(rd_gnt_0), 32'd1);
    check_eq("mid_rr_gnt1", 32'(rd_gnt_1), 32'd0);
    next_cyc(); set_rd(0, 0, '0, '0); set_rd(1, 0, '0, '0);
    repeat (4) next_cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
